// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding and
// default timing constants.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    RD_CAP  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5,
    ABORT   = 3'd6
  } mac_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 15;
  localparam int unsigned DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-cycle counter: synchronous clear, increment enable, terminal-count flag.
module wait_counter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TERMINAL = 14
) (
  input  logic clock,
  input  logic clear,
  input  logic cnt_clr,
  input  logic cnt_en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR load enables and memory strobes for
// one read or write per request, with a bounded wait for mem_ready.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic clear,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_ready,
  output logic MARin,
  output logic MDRin,
  output logic Read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic timeout
);

  mac_state_e state, state_nxt;
  logic       op_rd;
  logic       in_wait;
  logic       cnt_tc;

  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

  wait_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_wait_counter (
    .clock   (clock),
    .clear   (clear),
    .cnt_clr (state == ADDR),
    .cnt_en  (in_wait && !mem_ready),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      op_rd <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (rd_req || wr_req)) begin
        op_rd <= rd_req;
      end
    end
  end

  // mem_ready is tested before the terminal count so a late ready still completes
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rd_req || wr_req) state_nxt = ADDR;
      ADDR:    state_nxt = op_rd ? RD_WAIT : WR_WAIT;
      RD_WAIT: begin
        if (mem_ready)   state_nxt = RD_CAP;
        else if (cnt_tc) state_nxt = ABORT;
      end
      WR_WAIT: begin
        if (mem_ready)   state_nxt = FIN;
        else if (cnt_tc) state_nxt = ABORT;
      end
      RD_CAP:  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MARin   = 1'b0;
    MDRin   = 1'b0;
    Read    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      ADDR:    MARin = 1'b1;
      RD_WAIT: begin
        mem_rd = 1'b1;
        Read   = 1'b1;
      end
      RD_CAP:  begin
        MDRin = 1'b1;
        Read  = 1'b1;
      end
      WR_WAIT: mem_wr  = 1'b1;
      FIN:     done    = 1'b1;
      ABORT:   timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (default TIMEOUT and TIMEOUT=4)
// checked cycle by cycle against per-access expected output traces.
module tb_mem_access_ctrl;

  // Output vector bit order: {MARin, MDRin, Read, mem_rd, mem_wr, busy, done, timeout}
  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_ADDR  = 8'b1000_0100;
  localparam logic [7:0] V_RDW   = 8'b0011_0100;
  localparam logic [7:0] V_CAP   = 8'b0110_0100;
  localparam logic [7:0] V_WRW   = 8'b0000_1100;
  localparam logic [7:0] V_FIN   = 8'b0000_0110;
  localparam logic [7:0] V_ABORT = 8'b0000_0101;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear;
  logic rd_s, wr_s, rdy_s;
  int   sel;

  logic rd_a, wr_a, rdy_a, rd_b, wr_b, rdy_b;
  logic marin_a, mdrin_a, read_a, mrd_a, mwr_a, busy_a, done_a, to_a;
  logic marin_b, mdrin_b, read_b, mrd_b, mwr_b, busy_b, done_b, to_b;
  logic [7:0] out_a, out_b, obs_v;

  assign rd_a  = (sel == 0) ? rd_s  : 1'b0;
  assign wr_a  = (sel == 0) ? wr_s  : 1'b0;
  assign rdy_a = (sel == 0) ? rdy_s : 1'b0;
  assign rd_b  = (sel == 1) ? rd_s  : 1'b0;
  assign wr_b  = (sel == 1) ? wr_s  : 1'b0;
  assign rdy_b = (sel == 1) ? rdy_s : 1'b0;

  assign out_a = {marin_a, mdrin_a, read_a, mrd_a, mwr_a, busy_a, done_a, to_a};
  assign out_b = {marin_b, mdrin_b, read_b, mrd_b, mwr_b, busy_b, done_b, to_b};
  assign obs_v = (sel == 1) ? out_b : out_a;

  mem_access_ctrl dut_a (
    .clock(clock), .clear(clear), .rd_req(rd_a), .wr_req(wr_a), .mem_ready(rdy_a),
    .MARin(marin_a), .MDRin(mdrin_a), .Read(read_a), .mem_rd(mrd_a), .mem_wr(mwr_a),
    .busy(busy_a), .done(done_a), .timeout(to_a)
  );

  mem_access_ctrl #(.TIMEOUT(4)) dut_b (
    .clock(clock), .clear(clear), .rd_req(rd_b), .wr_req(wr_b), .mem_ready(rdy_b),
    .MARin(marin_b), .MDRin(mdrin_b), .Read(read_b), .mem_rd(mrd_b), .mem_wr(mwr_b),
    .busy(busy_b), .done(done_b), .timeout(to_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         rdy_q[$];   // 0/1 = forced mem_ready, 2 = don't care (random)

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    n_checks++;
    assert ((obs[4] & obs[3]) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_rdwr_excl: observed mem_rd=%b mem_wr=%b expected not both", tag, obs[4], obs[3]);
    end
  endtask

  // Expected trace of one access: ready arrives after 'delay' low wait cycles.
  task automatic add_txn(input bit rd, input int delay, input int t);
    exp_q.push_back(V_ADDR); rdy_q.push_back(2);
    if (delay < t) begin
      for (int j = 0; j <= delay; j++) begin
        exp_q.push_back(rd ? V_RDW : V_WRW);
        rdy_q.push_back((j == delay) ? 1 : 0);
      end
      if (rd) begin
        exp_q.push_back(V_CAP); rdy_q.push_back(2);
      end
      exp_q.push_back(V_FIN); rdy_q.push_back(2);
    end else begin
      for (int j = 0; j < t; j++) begin
        exp_q.push_back(rd ? V_RDW : V_WRW);
        rdy_q.push_back(0);
      end
      exp_q.push_back(V_ABORT); rdy_q.push_back(2);
    end
  endtask

  // Requests stay asserted through trace index hold_until (-1: one cycle only).
  task automatic run_seq(input string tag, input bit rd, input bit wr, input int hold_until);
    @(posedge clock); #1;
    rd_s  = rd;
    wr_s  = wr;
    rdy_s = 1'($urandom);
    @(negedge clock);
    check({tag, "_pre"}, obs_v, V_IDLE);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clock); #1;
      if (k > hold_until) begin
        rd_s = 1'b0;
        wr_s = 1'b0;
      end
      rdy_s = (rdy_q[k] == 2) ? 1'($urandom) : (rdy_q[k] == 1);
      @(negedge clock);
      check($sformatf("%s_c%0d", tag, k), obs_v, exp_q[k]);
    end
    @(posedge clock); #1;
    rd_s  = 1'b0;
    wr_s  = 1'b0;
    rdy_s = 1'($urandom);
    @(negedge clock);
    check({tag, "_post"}, obs_v, V_IDLE);
    exp_q.delete();
    rdy_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    bit rd, wr;
    int t, dly;

    clear = 1'b0;
    rd_s  = 1'b0;
    wr_s  = 1'b0;
    rdy_s = 1'b0;
    sel   = 0;

    #1;
    check("reset_a", out_a, V_IDLE);
    check("reset_b", out_b, V_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_a_clk", out_a, V_IDLE);
    check("reset_b_clk", out_b, V_IDLE);
    @(posedge clock); #1;
    clear = 1'b1;

    // Default TIMEOUT=15 instance
    sel = 0;
    add_txn(1, 0, 15);  run_seq("rd_fast", 1, 0, -1);
    add_txn(0, 0, 15);  run_seq("wr_fast", 0, 1, -1);
    add_txn(0, 5, 15);  run_seq("wr_5wait", 0, 1, -1);
    add_txn(1, 2, 15);  run_seq("rd_wr_both", 1, 1, -1);
    add_txn(1, 14, 15); run_seq("rd_ready_at_tc", 1, 0, -1);
    add_txn(0, 15, 15); run_seq("wr_abort", 0, 1, -1);

    add_txn(1, 1, 15);
    exp_q.push_back(V_IDLE); rdy_q.push_back(2);
    hold = exp_q.size() - 1;
    add_txn(1, 1, 15);
    run_seq("rd_held", 1, 0, hold);

    // TIMEOUT=4 instance
    sel = 1;
    add_txn(1, 4, 4); run_seq("rd_to4", 1, 0, -1);
    add_txn(1, 3, 4); run_seq("rd_ready_at_tc4", 1, 0, -1);
    add_txn(0, 3, 4); run_seq("wr_ready_at_tc4", 0, 1, -1);
    add_txn(0, 9, 4); run_seq("wr_to4", 0, 1, -1);

    // Asynchronous reset in the middle of a read wait
    sel = 0;
    @(posedge clock); #1;
    rd_s = 1'b1;
    @(posedge clock); #1;
    rd_s  = 1'b0;
    rdy_s = 1'b0;
    @(negedge clock);
    check("rst_mid_addr", obs_v, V_ADDR);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_mid_wait", obs_v, V_RDW);
    @(posedge clock); #3;
    clear = 1'b0;
    #1;
    check("rst_mid_async", obs_v, V_IDLE);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_mid_hold", obs_v, V_IDLE);
    @(posedge clock); #1;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rst_mid_quiet%0d", i), obs_v, V_IDLE);
      @(posedge clock); #1;
    end
    add_txn(1, 0, 15); run_seq("rd_after_rst", 1, 0, -1);

    // Randomized accesses on both instances
    for (int n = 0; n < 24; n++) begin
      sel = n % 2;
      t   = (sel == 1) ? 4 : 15;
      rd  = 1'($urandom);
      wr  = rd ? 1'($urandom) : 1'b1;
      dly = $urandom_range(0, t + 2);
      add_txn(rd, dly, t);
      run_seq($sformatf("rnd%0d", n), rd, wr, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for mem_ready before abort (1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the wait-counter width in bits.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port clear  input  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port rd_req  input  1  meaning a control-unit request for a memory read into MDR.
REQ-006 SHALL have port wr_req  input  1  meaning a control-unit request to write MDR contents to memory.
REQ-007 SHALL have port mem_ready  input  1  meaning memory has completed the current access.
REQ-008 SHALL have port MARin  output  1  meaning the MAR load enable.
REQ-009 SHALL have port MDRin  output  1  meaning the MDR load enable.
REQ-010 SHALL have port Read  output  1  meaning the MDR input-mux select (1 = Mdatain, 0 = BusMuxOut).
REQ-011 SHALL have port mem_rd  output  1  meaning the memory read strobe.
REQ-012 SHALL have port mem_wr  output  1  meaning the memory write strobe.
REQ-013 SHALL have port busy  output  1  meaning an access is in progress (state is not IDLE).
REQ-014 SHALL have port done  output  1  meaning a one-cycle pulse on successful completion.
REQ-015 SHALL have port timeout  output  1  meaning a one-cycle pulse on abort.

Function
REQ-016 SHALL implement states IDLE, ADDR, RD_WAIT, RD_CAP, WR_WAIT, FIN, ABORT.
REQ-017 IDLE SHALL go to ADDR on rd_req or wr_req, latching op (rd=1/wr=0); if both are asserted in the same cycle, read SHALL win and wr_req SHALL be ignored.
REQ-018 ADDR SHALL assert MARin for exactly one cycle, clear the wait counter, then go to RD_WAIT if op=rd, else WR_WAIT.
REQ-019 RD_WAIT SHALL assert mem_rd and Read continuously; when mem_ready=1 it SHALL go to RD_CAP.
REQ-020 RD_CAP SHALL assert MDRin=1 and Read=1 for exactly one cycle, then go to FIN.
REQ-021 WR_WAIT SHALL assert mem_wr with Read=0 and MDRin=0; when mem_ready=1 it SHALL go to FIN.
REQ-022 In RD_WAIT/WR_WAIT with mem_ready=0, the counter SHALL increment; when the counter equals TIMEOUT-1 and mem_ready=0, next state SHALL be ABORT.
REQ-023 mem_ready=1 in the same cycle the counter reaches TIMEOUT-1 SHALL complete normally (ready has priority over timeout).
REQ-024 FIN SHALL pulse done for one cycle and return to IDLE; ABORT SHALL pulse timeout for one cycle and return to IDLE, with MDRin never asserted.
REQ-025 Requests SHALL be ignored while busy=1; a request held through FIN/ABORT SHALL start a new access from IDLE one cycle later.
REQ-026 Minimum latency SHALL be: read 4 cycles from request to done (ADDR, RD_WAIT, RD_CAP, FIN) with mem_ready already high; write 3 cycles.
REQ-027 mem_ready outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-028 All outputs SHALL be registered-state decodes (Moore); no output SHALL depend combinationally on inputs.
REQ-029 mem_rd and mem_wr SHALL never be high simultaneously.

Reset
REQ-030 clear=0 SHALL immediately force state IDLE, counter 0, op rd, and all outputs 0, regardless of clock.
REQ-031 Reset asserted mid-access SHALL abort it silently (no done, no timeout pulse).
REQ-032 After clear rises, the first request SHALL be accepted on the next rising edge.

Structure
REQ-033 The state encoding enum and the default TIMEOUT constant SHALL live in the shared cpu package.
REQ-034 The wait counter SHALL be a sub-module wait_counter (clear-to-zero, increment enable, terminal-count output).

Verification
REQ-035 Read, mem_ready high throughout -> MARin in cycle 1, MDRin+Read in cycle 3, done in cycle 4, busy high for cycles 1-4.
REQ-036 Write, mem_ready asserted after 5 wait cycles -> mem_wr high for 6 cycles, done one cycle after ready, MDRin never high.
REQ-037 Read with TIMEOUT=4 and mem_ready held low -> mem_rd high for 4 cycles, timeout pulse, no MDRin, back in IDLE.
REQ-038 rd_req and wr_req high in the same cycle -> read sequence only; mem_wr stays 0.
REQ-039 clear pulsed low during RD_WAIT -> outputs 0 asynchronously, no done/timeout, next rd_req served normally.
REQ-040 mem_ready rises exactly on the cycle the counter reaches TIMEOUT-1 -> done, not timeout.
